// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port register file.
package rf_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;
    localparam logic [ADDR_W_DEF-1:0] ZERO_ADDR = '0;

    // Low bit index of lane idx in a bus packed as lanes of the given width.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One read port: reset/zero/disable/bypass/storage priority mux plus operand-pending flag.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NWR    = 2
) (
    input  logic                  i_rst,
    input  logic                  i_re,
    input  logic [ADDR_W-1:0]     i_raddr,
    input  logic [NWR-1:0]        i_we,
    input  logic [NWR*ADDR_W-1:0] i_waddr,
    input  logic [NWR*DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0]     i_stored,
    input  logic                  i_busy,
    output logic [DATA_W-1:0]     o_rdata,
    output logic                  o_rbusy
);

    logic              w_hit;
    logic [DATA_W-1:0] w_byp;
    logic              w_zero;

    assign w_zero = (i_raddr == ADDR_W'(ZERO_ADDR));

    // Bypass search: later (higher-index) write ports override earlier ones.
    always_comb begin
        w_hit = 1'b0;
        w_byp = DATA_W'(ZERO_WORD);
        for (int i = 0; i < int'(NWR); i++) begin
            if (i_we[i] && (i_waddr[slice_lo(i, ADDR_W) +: ADDR_W] == i_raddr)) begin
                w_hit = 1'b1;
                w_byp = i_wdata[slice_lo(i, DATA_W) +: DATA_W];
            end
        end
    end

    // Read data priority mux and pending flag; a same-cycle writeback satisfies the operand.
    always_comb begin
        o_rdata = DATA_W'(ZERO_WORD);
        o_rbusy = 1'b0;
        if (i_rst || w_zero || !i_re) begin
            o_rdata = DATA_W'(ZERO_WORD);
        end else if (w_hit) begin
            o_rdata = w_byp;
        end else begin
            o_rdata = i_stored;
        end
        if (!i_rst && i_re && !w_zero && i_busy && !w_hit) begin
            o_rbusy = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass and a per-register busy scoreboard.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NWR-1:0]        i_we,
    input  logic [NWR*ADDR_W-1:0] i_waddr,
    input  logic [NWR*DATA_W-1:0] i_wdata,
    input  logic [NRD-1:0]        i_re,
    input  logic [NRD*ADDR_W-1:0] i_raddr,
    output logic [NRD*DATA_W-1:0] o_rdata,
    output logic [NRD-1:0]        o_rbusy,
    output logic                  o_stall,
    input  logic                  i_bset,
    input  logic [ADDR_W-1:0]     i_baddr
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_d;
    logic [ADDR_W-1:0] w_waddr [NWR];
    logic [DATA_W-1:0] w_wdata [NWR];

    for (genvar i = 0; i < int'(NWR); i++) begin : g_wr_unpack
        assign w_waddr[i] = i_waddr[i*ADDR_W +: ADDR_W];
        assign w_wdata[i] = i_wdata[i*DATA_W +: DATA_W];
    end

    // Storage update; writes are applied in port order so the higher index wins.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                r_mem[k] <= DATA_W'(ZERO_WORD);
            end
        end else begin
            for (int i = 0; i < int'(NWR); i++) begin
                if (i_we[i] && (w_waddr[i] != ADDR_W'(ZERO_ADDR))) begin
                    r_mem[w_waddr[i]] <= w_wdata[i];
                end
            end
        end
    end

    // Scoreboard next state: writebacks clear, then a new issue sets (set wins).
    always_comb begin
        w_busy_d = r_busy;
        for (int i = 0; i < int'(NWR); i++) begin
            if (i_we[i] && (w_waddr[i] != ADDR_W'(ZERO_ADDR))) begin
                w_busy_d[w_waddr[i]] = 1'b0;
            end
        end
        if (i_bset && (i_baddr != ADDR_W'(ZERO_ADDR))) begin
            w_busy_d[i_baddr] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_d;
        end
    end

    for (genvar j = 0; j < int'(NRD); j++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        assign w_ra = i_raddr[j*ADDR_W +: ADDR_W];

        rf_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NWR    (NWR)
        ) u_rd (
            .i_rst    (i_rst),
            .i_re     (i_re[j]),
            .i_raddr  (w_ra),
            .i_we     (i_we),
            .i_waddr  (i_waddr),
            .i_wdata  (i_wdata),
            .i_stored (r_mem[w_ra]),
            .i_busy   (r_busy[w_ra]),
            .o_rdata  (o_rdata[j*DATA_W +: DATA_W]),
            .o_rbusy  (o_rbusy[j])
        );
    end

    assign o_stall = |(i_re & o_rbusy);

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, corner sequences, random vs model.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int NW    = 2;
    localparam int DEPTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [NW-1:0]    we;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdata;
    logic [NR-1:0]    re;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rbusy;
    logic             stall;
    logic             bset;
    logic [AW-1:0]    baddr;

    always #5 clk = ~clk;

    regfile_mp #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NRD    (NR),
        .NWR    (NW)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_we    (we),
        .i_waddr (waddr),
        .i_wdata (wdata),
        .i_re    (re),
        .i_raddr (raddr),
        .o_rdata (rdata),
        .o_rbusy (rbusy),
        .o_stall (stall),
        .i_bset  (bset),
        .i_baddr (baddr)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: plain arrays of register contents and pending producers.
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_busy [DEPTH];

    typedef struct {
        logic [1:0]  we;
        int          wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [1:0]  re;
        int          ra0, ra1;
        logic        bs;
        int          ba;
        logic [31:0] e_rd0, e_rd1;
        logic        e_rb0, e_rb1, e_st;
    } vec_t;

    vec_t vecs[14];

    task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [1:0] w, input int wa0, input int wa1,
                         input logic [31:0] wd0, input logic [31:0] wd1,
                         input logic [1:0] r, input int ra0, input int ra1,
                         input logic bs, input int ba);
        we    = w;
        waddr = {AW'(wa1), AW'(wa0)};
        wdata = {wd1, wd0};
        re    = r;
        raddr = {AW'(ra1), AW'(ra0)};
        bset  = bs;
        baddr = AW'(ba);
    endtask

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) begin
            m_mem[k]  = '0;
            m_busy[k] = 1'b0;
        end
    endtask

    // Expected read of port j from the architectural rules.
    function automatic logic [DW-1:0] ref_rd(input int j);
        int ra;
        logic [DW-1:0] v;
        ra = int'(raddr[j*AW +: AW]);
        if (rst || ra == 0 || !re[j]) return '0;
        v = m_mem[ra];
        for (int i = 0; i < NW; i++)
            if (we[i] && int'(waddr[i*AW +: AW]) == ra) v = wdata[i*DW +: DW];
        return v;
    endfunction

    function automatic logic ref_rb(input int j);
        int ra;
        bit written;
        ra = int'(raddr[j*AW +: AW]);
        written = 1'b0;
        for (int i = 0; i < NW; i++)
            if (we[i] && int'(waddr[i*AW +: AW]) == ra) written = 1'b1;
        return !rst && re[j] && ra != 0 && m_busy[ra] && !written;
    endfunction

    task automatic check_model(input string tag);
        logic exp_st;
        exp_st = 1'b0;
        for (int j = 0; j < NR; j++) begin
            cmp($sformatf("%s rdata%0d", tag, j), rdata[j*DW +: DW], ref_rd(j));
            cmp($sformatf("%s rbusy%0d", tag, j), DW'(rbusy[j]), DW'(ref_rb(j)));
            exp_st = exp_st | (re[j] & ref_rb(j));
        end
        cmp($sformatf("%s stall", tag), DW'(stall), DW'(exp_st));
    endtask

    // Advance one clock and fold the applied inputs into the model.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < NW; i++) begin
                int wa;
                wa = int'(waddr[i*AW +: AW]);
                if (we[i] && wa != 0) begin
                    m_mem[wa]  = wdata[i*DW +: DW];
                    m_busy[wa] = 1'b0;
                end
            end
            if (bset && baddr != 0) m_busy[int'(baddr)] = 1'b1;
        end
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [1:0] w, input int wa0, input int wa1,
                                input logic [31:0] wd0, input logic [31:0] wd1,
                                input logic [1:0] r, input int ra0, input int ra1,
                                input logic bs, input int ba,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic b0, input logic b1, input logic st);
        vec_t v;
        v.we = w; v.wa0 = wa0; v.wa1 = wa1; v.wd0 = wd0; v.wd1 = wd1;
        v.re = r; v.ra0 = ra0; v.ra1 = ra1; v.bs = bs; v.ba = ba;
        v.e_rd0 = e0; v.e_rd1 = e1; v.e_rb0 = b0; v.e_rb1 = b1; v.e_st = st;
        return v;
    endfunction

    initial begin
        // Collision, bypass, zero register, scoreboard lifecycle, set-vs-clear.
        vecs[0]  = mk(2'b11, 7, 7, 32'hAAAA, 32'h5555, 2'b11, 7, 7, 0, 0,
                      32'h5555, 32'h5555, 0, 0, 0);
        vecs[1]  = mk(2'b00, 0, 0, 0, 0, 2'b11, 7, 7, 0, 0, 32'h5555, 32'h5555, 0, 0, 0);
        vecs[2]  = mk(2'b01, 3, 0, 32'hDEAD, 0, 2'b11, 3, 3, 0, 0,
                      32'hDEAD, 32'hDEAD, 0, 0, 0);
        vecs[3]  = mk(2'b11, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 0, 0, 1, 0,
                      0, 0, 0, 0, 0);
        vecs[4]  = mk(2'b00, 0, 0, 0, 0, 2'b11, 0, 3, 0, 0, 0, 32'hDEAD, 0, 0, 0);
        vecs[5]  = mk(2'b00, 0, 0, 0, 0, 2'b11, 9, 9, 1, 9, 0, 0, 0, 0, 0);
        vecs[6]  = mk(2'b00, 0, 0, 0, 0, 2'b11, 9, 9, 0, 0, 0, 0, 1, 1, 1);
        vecs[7]  = mk(2'b00, 0, 0, 0, 0, 2'b11, 9, 9, 0, 0, 0, 0, 1, 1, 1);
        vecs[8]  = mk(2'b10, 0, 9, 0, 32'h42, 2'b11, 9, 9, 0, 0, 32'h42, 32'h42, 0, 0, 0);
        vecs[9]  = mk(2'b00, 0, 0, 0, 0, 2'b11, 9, 9, 0, 0, 32'h42, 32'h42, 0, 0, 0);
        vecs[10] = mk(2'b00, 0, 0, 0, 0, 2'b00, 4, 4, 1, 4, 0, 0, 0, 0, 0);
        vecs[11] = mk(2'b01, 4, 0, 32'h77, 0, 2'b01, 4, 4, 1, 4, 32'h77, 0, 0, 0, 0);
        vecs[12] = mk(2'b00, 0, 0, 0, 0, 2'b11, 4, 4, 0, 0, 32'h77, 32'h77, 1, 1, 1);
        vecs[13] = mk(2'b00, 0, 0, 0, 0, 2'b10, 4, 4, 0, 0, 0, 32'h77, 0, 1, 1);

        rst = 1'b1;
        model_reset();
        apply(2'b11, 5, 5, 32'h1, 32'h2, 2'b11, 5, 5, 1, 5);
        #1;
        cmp("reset rdata0", rdata[DW-1:0], '0);
        cmp("reset rbusy", DW'(rbusy), '0);
        cmp("reset stall", DW'(stall), '0);
        @(negedge clk);
        @(negedge clk);
        apply(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        rst = 1'b0;

        for (int n = 0; n < 14; n++) begin
            apply(vecs[n].we, vecs[n].wa0, vecs[n].wa1, vecs[n].wd0, vecs[n].wd1,
                  vecs[n].re, vecs[n].ra0, vecs[n].ra1, vecs[n].bs, vecs[n].ba);
            #1;
            cmp($sformatf("vec%0d rdata0", n), rdata[DW-1:0], vecs[n].e_rd0);
            cmp($sformatf("vec%0d rdata1", n), rdata[2*DW-1:DW], vecs[n].e_rd1);
            cmp($sformatf("vec%0d rbusy0", n), DW'(rbusy[0]), DW'(vecs[n].e_rb0));
            cmp($sformatf("vec%0d rbusy1", n), DW'(rbusy[1]), DW'(vecs[n].e_rb1));
            cmp($sformatf("vec%0d stall", n), DW'(stall), DW'(vecs[n].e_st));
            tick();
        end

        // Asynchronous reset between edges while r5 holds data and is pending.
        apply(2'b01, 5, 0, 32'h1234, 0, 2'b00, 0, 0, 0, 0);
        #1; tick();
        apply(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1, 5);
        #1; tick();
        apply(2'b00, 0, 0, 0, 0, 2'b11, 5, 5, 0, 0);
        #1;
        cmp("pre-rst rdata0", rdata[DW-1:0], 32'h1234);
        cmp("pre-rst rbusy0", DW'(rbusy[0]), DW'(1));
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        cmp("mid-rst rdata0", rdata[DW-1:0], '0);
        cmp("mid-rst rbusy", DW'(rbusy), '0);
        cmp("mid-rst stall", DW'(stall), '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        cmp("post-rst rdata0", rdata[DW-1:0], '0);
        cmp("post-rst rbusy0", DW'(rbusy[0]), '0);
        check_model("post-rst");
        tick();

        // Random traffic over a small address window to force hits and collisions.
        for (int n = 0; n < 400; n++) begin
            apply(2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom, $urandom, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  1'($urandom_range(0, 1)), $urandom_range(0, 7));
            #1;
            check_model($sformatf("rnd%0d", n));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file with a per-register busy scoreboard, the successor to the two-read/one-write register file in the decode stage. It provides NRD read ports with write-to-read bypass across NWR write ports and deterministic write-port priority. It also tracks which registers have an outstanding producer so that decode can raise a stall. Register 0 always reads as zero and is never busy.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth is 2**ADDR_W
- NRD, 2, number of read ports (1..4)
- NWR, 2, number of write ports (1..2)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- we  in  NWR  per-port write enable
- waddr  in  NWR*ADDR_W  write addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
- wdata  in  NWR*DATA_W  write data, packed the same way
- re  in  NRD  per-port read enable
- raddr  in  NRD*ADDR_W  read addresses, packed
- rdata  out  NRD*DATA_W  read data, packed, combinational
- rbusy  out  NRD  operand of port j still pending, combinational
- stall  out  1  OR over j of (re[j] & rbusy[j])
- bset  in  1  issue: mark register baddr busy
- baddr  in  ADDR_W  destination register of the issuing instruction

## Operation
- Storage: 2**ADDR_W × DATA_W registers plus a 2**ADDR_W-bit busy vector.
- Write: on a rising edge with rst low, for each port i with we[i]=1 and waddr[i]≠0, the entry takes wdata[i].
  - If two ports hit the same address, the higher index wins.
  - Writes to address 0 are discarded.
- Busy clear: any accepted write (we[i]=1, waddr≠0) clears busy[waddr[i]] at the same edge.
- Busy set: bset=1 with baddr≠0 sets busy[baddr].
  - If a set and a clear target the same address in the same cycle, the set wins, because a new producer has been issued.
  - bset with baddr=0 is ignored.
- Read port j, evaluated in priority order:
  1. rst=1 → 0.
  2. raddr=0 → 0.
  3. re=0 → 0.
  4. Highest-index write port i with we[i]=1 and waddr[i]=raddr[j] → wdata[i] (bypass).
  5. Otherwise → stored entry.
- rbusy[j]:
  - Is 1 when re[j]=1, raddr[j]≠0, busy[raddr[j]]=1, and no write port is currently writing raddr[j].
  - Writeback in the same cycle satisfies the operand, so rbusy is 0 in that case.
  - rbusy is 0 while rst=1.
- bset does not affect rbusy in the cycle it is asserted. Same-cycle issue-after-issue hazards are handled by decode.

## Timing
- Reset, asynchronous: all entries become 0 and all busy bits become 0 immediately.
  - rdata=0, rbusy=0 and stall=0 for as long as rst=1.
  - A write or bset coinciding with reset assertion is lost.
- Write latency: one edge to storage; zero cycles to readers via bypass.
- Busy latency: bset in cycle n is visible on rbusy from cycle n+1.
- A producer issued in cycle n with writeback in cycle n+k gives rbusy=1 in cycles n+1..n+k-1 and rbusy=0 in cycle n+k (bypass).
- rdata, rbusy and stall are purely combinational from the inputs and state; there is no registered output.

## Structure
- Shared package rf_pkg:
  - DATA_W and ADDR_W defaults
  - ZERO_WORD
  - ZERO_ADDR
  - helper function for the packed-slice index
- One sub-module, rf_read_port, generated NRD times. It contains:
  - the priority mux (rst/zero/disable/bypass/storage)
  - the rbusy logic for one port
- The top level holds storage, the busy vector, the write/priority logic and the stall reduction.

## Test plan
- **Reset mid-operation:** preload r5=0x1234 and set busy[5]; assert rst asynchronously between edges → rdata=0 and rbusy=0 immediately; after release, reading r5 gives 0 and busy[5]=0.
- **Zero register:** write 0xFFFFFFFF to r0 on both ports and bset baddr=0 → every read of r0 returns 0, rbusy=0, busy vector unchanged.
- **Dual-write collision:** we=2'b11, both waddr=7, wdata0=0xAAAA, wdata1=0x5555 → same-cycle read of r7 returns 0x5555; next cycle the stored r7 is 0x5555.
- **Bypass on all ports:** write port 0 writes r3=0xDEAD while read ports 0 and 1 both read r3 → both return 0xDEAD in the same cycle.
- **Scoreboard lifecycle:** bset r9 in cycle 0, write r9=0x42 in cycle 3, read r9 in cycles 1..4 → rbusy=1 and stall=1 in cycles 1–2; in cycle 3 rbusy=0 and rdata=0x42 (bypass); in cycle 4 rbusy=0 and rdata=0x42 from storage.
- **Set and clear same address:** busy[4]=1; in one cycle write r4 and bset baddr=4 → in the next cycle busy[4]=1 and a read of r4 shows rbusy=1 while rdata holds the new value.
